// File: rtl/status_ctrl_pkg.sv
// Shared constants for the status-register write controller: default sizes and
// bit positions of the one-hot grant vector, highest priority first.
package status_ctrl_pkg;

  localparam int NUM_STATUS_BITS_DEF = 3;
  localparam int SHADOW_DEPTH_DEF    = 4;

  localparam int GNT_W       = 4;
  localparam int GNT_RESTORE = 3;
  localparam int GNT_SAVE    = 2;
  localparam int GNT_DEC     = 1;
  localparam int GNT_ALU     = 0;

  typedef logic [GNT_W-1:0] gnt_vec_t;

  function automatic gnt_vec_t gnt_onehot(input int idx);
    return gnt_vec_t'(1) << idx;
  endfunction

  // Stack count must reach DEPTH itself, hence one bit more than the index.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/status_shadow_stack.sv
// LIFO of saved status words for nested interrupts. Pop takes precedence if both
// strobes arrive together; the controller never issues both in one cycle.
module status_shadow_stack
  import status_ctrl_pkg::*;
#(
  parameter int W     = NUM_STATUS_BITS_DEF,
  parameter int DEPTH = SHADOW_DEPTH_DEF,
  localparam int PTR_W = ptr_width(DEPTH)
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     push_data,
  output logic [W-1:0]     top,
  output logic [PTR_W-1:0] depth,
  output logic             full,
  output logic             empty
);

  localparam int AW = PTR_W - 1;

  logic [W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0] count;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign wr_idx  = AW'(count);
  assign top_idx = AW'(count - 1'b1);

  assign full  = (count == PTR_W'(DEPTH));
  assign empty = (count == '0);
  assign depth = count;
  assign top   = empty ? '0 : mem[top_idx];

  always_ff @(posedge clk) begin
    if (res) begin
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (pop && !empty) begin
      count <= count - 1'b1;
    end else if (push && !full) begin
      mem[wr_idx] <= push_data;
      count       <= count + 1'b1;
    end
  end

endmodule

// File: rtl/status_ctrl.sv
// Arbitrates every write into the CPU status register (restore > save > decoder > ALU)
// and keeps the shadow stack used for interrupt save/restore.
module status_ctrl
  import status_ctrl_pkg::*;
#(
  parameter int NUM_STATUS_BITS = NUM_STATUS_BITS_DEF,
  parameter int SHADOW_DEPTH    = SHADOW_DEPTH_DEF,
  localparam int PTR_W          = ptr_width(SHADOW_DEPTH)
) (
  input  logic                       clk,
  input  logic                       res,
  input  logic [NUM_STATUS_BITS-1:0] status,
  input  logic                       alu_req,
  input  logic                       dec_req,
  input  logic [NUM_STATUS_BITS-1:0] dec_val,
  input  logic                       irq_save,
  input  logic                       irq_restore,
  output logic                       alu_gnt,
  output logic                       dec_gnt,
  output logic                       save_gnt,
  output logic                       restore_gnt,
  output logic                       stat_wr_en,
  output logic                       stat_sel_alu,
  output logic [NUM_STATUS_BITS-1:0] stat_dec_val,
  output logic [PTR_W-1:0]           depth,
  output logic                       ovf_err,
  output logic                       unf_err
);

  logic [NUM_STATUS_BITS-1:0] stk_top;
  logic                       stk_full;
  logic                       stk_empty;
  logic                       restore_ok;
  logic                       save_ok;
  gnt_vec_t                   gnt;

  status_shadow_stack #(
    .W     (NUM_STATUS_BITS),
    .DEPTH (SHADOW_DEPTH)
  ) u_stack (
    .clk       (clk),
    .res       (res),
    .push      (gnt[GNT_SAVE]),
    .pop       (gnt[GNT_RESTORE]),
    .push_data (status),
    .top       (stk_top),
    .depth     (depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  // A save or restore that cannot be honoured drops out of arbitration so the
  // lower-priority requesters still get the write slot this cycle.
  assign restore_ok = irq_restore && !stk_empty;
  assign save_ok    = irq_save && !stk_full;

  always_comb begin
    gnt = '0;
    if (restore_ok) begin
      gnt = gnt_onehot(GNT_RESTORE);
    end else if (save_ok) begin
      gnt = gnt_onehot(GNT_SAVE);
    end else if (dec_req) begin
      gnt = gnt_onehot(GNT_DEC);
    end else if (alu_req) begin
      gnt = gnt_onehot(GNT_ALU);
    end
  end

  assign restore_gnt = gnt[GNT_RESTORE];
  assign save_gnt    = gnt[GNT_SAVE];
  assign dec_gnt     = gnt[GNT_DEC];
  assign alu_gnt     = gnt[GNT_ALU];

  // Save clears the flags, so it writes zero through the decoder path.
  always_comb begin
    stat_wr_en   = |gnt;
    stat_sel_alu = gnt[GNT_ALU];
    stat_dec_val = '0;
    if (gnt[GNT_RESTORE]) begin
      stat_dec_val = stk_top;
    end else if (gnt[GNT_DEC]) begin
      stat_dec_val = dec_val;
    end
  end

  // A save blocked only by a winning restore is not an overflow; it is retried.
  always_ff @(posedge clk) begin
    if (res) begin
      ovf_err <= 1'b0;
      unf_err <= 1'b0;
    end else begin
      if (irq_restore && stk_empty) begin
        unf_err <= 1'b1;
      end
      if (irq_save && stk_full && !restore_ok) begin
        ovf_err <= 1'b1;
      end
    end
  end

  always_comb begin
    assert ($onehot0(gnt));
  end

endmodule

// File: tb/tb_status_ctrl.sv
// Directed bench for status_ctrl: an emulated status register in front of the DUT,
// a queue-based reference model checked every cycle, plus literal spot checks.
module tb_status_ctrl;

  localparam int NSB   = 3;
  localparam int DEPTH = 4;
  localparam int PW    = 3;

  logic           clk;
  logic           res;
  logic [NSB-1:0] status;
  logic           alu_req;
  logic           dec_req;
  logic [NSB-1:0] dec_val;
  logic           irq_save;
  logic           irq_restore;
  logic           alu_gnt;
  logic           dec_gnt;
  logic           save_gnt;
  logic           restore_gnt;
  logic           stat_wr_en;
  logic           stat_sel_alu;
  logic [NSB-1:0] stat_dec_val;
  logic [PW-1:0]  depth;
  logic           ovf_err;
  logic           unf_err;
  logic [NSB-1:0] alu_flags;

  int n_vec = 0;
  int n_bad = 0;

  status_ctrl #(.NUM_STATUS_BITS(NSB), .SHADOW_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .res          (res),
    .status       (status),
    .alu_req      (alu_req),
    .dec_req      (dec_req),
    .dec_val      (dec_val),
    .irq_save     (irq_save),
    .irq_restore  (irq_restore),
    .alu_gnt      (alu_gnt),
    .dec_gnt      (dec_gnt),
    .save_gnt     (save_gnt),
    .restore_gnt  (restore_gnt),
    .stat_wr_en   (stat_wr_en),
    .stat_sel_alu (stat_sel_alu),
    .stat_dec_val (stat_dec_val),
    .depth        (depth),
    .ovf_err      (ovf_err),
    .unf_err      (unf_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Emulated status register fed by the DUT's write port.
  always @(posedge clk) begin
    if (res) status <= '0;
    else if (stat_wr_en) status <= stat_sel_alu ? alu_flags : stat_dec_val;
  end

  // Reference model: saved words in a queue, sticky error bits.
  logic [NSB-1:0] mq[$];
  bit m_ovf, m_unf, model_valid;

  // 0 none, 1 alu, 2 dec, 3 save, 4 restore
  function automatic int winner_of(int n);
    if (irq_restore && n > 0) return 4;
    if (irq_save && n < DEPTH) return 3;
    if (dec_req) return 2;
    if (alu_req) return 1;
    return 0;
  endfunction

  always @(posedge clk) begin
    if (res) begin
      mq.delete();
      m_ovf = 0;
      m_unf = 0;
      model_valid = 1;
    end else if (model_valid) begin
      int n;
      int w;
      n = mq.size();
      w = winner_of(n);
      if (irq_restore && n == 0) m_unf = 1;
      if (irq_save && n == DEPTH && w != 4) m_ovf = 1;
      if (w == 4) void'(mq.pop_back());
      if (w == 3) mq.push_back(status);
    end
  end

  always @(negedge clk) begin
    if (model_valid && !res) begin
      int n;
      int w;
      logic [NSB-1:0] e_val;
      logic [13:0] exp_v, act_v;
      n = mq.size();
      w = winner_of(n);
      e_val = '0;
      if (w == 4) e_val = mq[n-1];
      else if (w == 2) e_val = dec_val;
      exp_v = {w == 1, w == 2, w == 3, w == 4, w != 0, w == 1, e_val, PW'(n), m_ovf, m_unf};
      act_v = {alu_gnt, dec_gnt, save_gnt, restore_gnt, stat_wr_en, stat_sel_alu,
               stat_dec_val, depth, ovf_err, unf_err};
      n_vec++;
      if (act_v !== exp_v) begin
        n_bad++;
        $display("FAIL model_cycle t=%0t got=%b want=%b (alu,dec,save,rst,wr,sel,val,depth,ovf,unf)",
                 $time, act_v, exp_v);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic write_status(input logic [NSB-1:0] v);
    dec_req = 1; dec_val = v;
    step();
    dec_req = 0; dec_val = '0;
  endtask

  logic [NSB-1:0] nest_vals [3];
  logic [3:0]     pat_req   [8];
  logic [NSB-1:0] pat_val   [8];

  initial begin
    res = 1; alu_req = 0; dec_req = 0; dec_val = '0;
    irq_save = 0; irq_restore = 0; alu_flags = 3'b110;
    nest_vals[0] = 3'b001; nest_vals[1] = 3'b010; nest_vals[2] = 3'b100;
    // {irq_restore, irq_save, dec_req, alu_req}
    pat_req[0] = 4'b0011; pat_val[0] = 3'b111;
    pat_req[1] = 4'b0101; pat_val[1] = 3'b001;
    pat_req[2] = 4'b0111; pat_val[2] = 3'b010;
    pat_req[3] = 4'b1011; pat_val[3] = 3'b100;
    pat_req[4] = 4'b1111; pat_val[4] = 3'b011;
    pat_req[5] = 4'b1001; pat_val[5] = 3'b101;
    pat_req[6] = 4'b0001; pat_val[6] = 3'b000;
    pat_req[7] = 4'b0000; pat_val[7] = 3'b110;

    step(); step();
    res = 0;
    settle();
    chk("reset_depth", int'(depth), 0);
    chk("reset_ovf", int'(ovf_err), 0);
    chk("reset_unf", int'(unf_err), 0);
    chk("reset_wr_en", int'(stat_wr_en), 0);

    alu_req = 1; dec_req = 1; dec_val = 3'b011;
    settle();
    chk("dec_over_alu_dec_gnt", int'(dec_gnt), 1);
    chk("dec_over_alu_alu_gnt", int'(alu_gnt), 0);
    chk("dec_over_alu_val", int'(stat_dec_val), 3);
    step();
    chk("dec_written_status", int'(status), 3);
    dec_req = 0; dec_val = '0;
    settle();
    chk("alu_gnt", int'(alu_gnt), 1);
    chk("alu_sel", int'(stat_sel_alu), 1);
    step();
    alu_req = 0;
    chk("alu_written_status", int'(status), 6);

    write_status(3'b101);
    chk("pre_save_status", int'(status), 5);
    irq_save = 1;
    settle();
    chk("save_gnt", int'(save_gnt), 1);
    chk("save_clears_val", int'(stat_dec_val), 0);
    step();
    irq_save = 0;
    chk("save_depth", int'(depth), 1);
    chk("save_status_cleared", int'(status), 0);
    irq_restore = 1;
    settle();
    chk("restore_val", int'(stat_dec_val), 5);
    step();
    irq_restore = 0;
    chk("restore_depth", int'(depth), 0);
    chk("restore_status", int'(status), 5);

    for (int i = 0; i < 3; i++) begin
      write_status(nest_vals[i]);
      irq_save = 1;
      step();
      irq_save = 0;
    end
    chk("nest_depth", int'(depth), 3);
    for (int i = 2; i >= 0; i--) begin
      irq_restore = 1;
      settle();
      chk("nest_restore_val", int'(stat_dec_val), int'(nest_vals[i]));
      step();
      irq_restore = 0;
      chk("nest_restore_status", int'(status), int'(nest_vals[i]));
    end
    chk("nest_depth_empty", int'(depth), 0);

    irq_save = 1;
    for (int i = 0; i < 4; i++) step();
    chk("full_depth", int'(depth), 4);
    settle();
    chk("ovf_save_gnt", int'(save_gnt), 0);
    chk("ovf_no_write", int'(stat_wr_en), 0);
    dec_req = 1; dec_val = 3'b010;
    settle();
    chk("ovf_dec_still_granted", int'(dec_gnt), 1);
    step();
    irq_save = 0; dec_req = 0; dec_val = '0;
    chk("ovf_err", int'(ovf_err), 1);
    chk("ovf_depth", int'(depth), 4);

    irq_restore = 1;
    for (int i = 0; i < 4; i++) step();
    settle();
    chk("unf_restore_gnt", int'(restore_gnt), 0);
    chk("unf_no_write", int'(stat_wr_en), 0);
    step();
    irq_restore = 0;
    chk("unf_err", int'(unf_err), 1);
    chk("ovf_sticky", int'(ovf_err), 1);

    irq_save = 1;
    step();
    irq_restore = 1;
    settle();
    chk("both_restore_gnt", int'(restore_gnt), 1);
    chk("both_save_gnt", int'(save_gnt), 0);
    step();
    irq_save = 0; irq_restore = 0;
    chk("both_depth", int'(depth), 0);

    for (int i = 0; i < 8; i++) begin
      {irq_restore, irq_save, dec_req, alu_req} = pat_req[i];
      dec_val = pat_val[i];
      alu_flags = ~pat_val[i];
      step();
    end
    {irq_restore, irq_save, dec_req, alu_req} = 4'b0000;

    irq_save = 1;
    step(); step();
    irq_save = 0;
    chk("mid_nest_depth", int'(depth), 2);
    res = 1;
    step();
    res = 0;
    chk("reset_mid_nest_depth", int'(depth), 0);
    chk("reset_clears_ovf", int'(ovf_err), 0);
    chk("reset_clears_unf", int'(unf_err), 0);
    irq_restore = 1;
    settle();
    chk("reset_discards_entries", int'(restore_gnt), 0);
    step();
    irq_restore = 0;
    step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
